// File: rtl/affine_seq_pkg.sv
// Shared definitions for the affine_seq block.
//   state_t      : sequencer states, IDLE through DONE in execution order.
//   A11..B2      : coefficient register-file addresses (cfg_addr values).
//   RA/RB/RADD/RMUL : function codes of the shared picoMIPS ALU, taken
//                  from its code table so the sequencer and the ALU stay
//                  in agreement.
package affine_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_M11  = 4'd1,
    ST_M12  = 4'd2,
    ST_S1   = 4'd3,
    ST_B1   = 4'd4,
    ST_M21  = 4'd5,
    ST_M22  = 4'd6,
    ST_S2   = 4'd7,
    ST_B2   = 4'd8,
    ST_DONE = 4'd9
  } state_t;

  // Coefficient addresses; 6 and 7 are unused and ignored on write.
  localparam logic [2:0] A11 = 3'd0;
  localparam logic [2:0] A12 = 3'd1;
  localparam logic [2:0] A21 = 3'd2;
  localparam logic [2:0] A22 = 3'd3;
  localparam logic [2:0] B1  = 3'd4;
  localparam logic [2:0] B2  = 3'd5;

  // picoMIPS ALU function codes.
  localparam logic [1:0] RA   = 2'd0;  // result = a
  localparam logic [1:0] RB   = 2'd1;  // result = b
  localparam logic [1:0] RADD = 2'd2;  // result = a + b, wraps mod 2^n
  localparam logic [1:0] RMUL = 2'd3;  // result = Q1.7 product, bits [14:7]

endpackage

// File: rtl/affine_seq_coef_rf.sv
// Coefficient register file: six n-bit registers with one write port and
// six parallel read outputs.
//   clk, reset : clock, asynchronous active-high reset (clears all to 0)
//   we         : write strobe (already gated to IDLE by the parent)
//   addr, data : write address (A11..B2; 6/7 ignored) and value
//   a11..b2    : registered coefficient values
module affine_seq_coef_rf
  import affine_seq_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [2:0]   addr,
  input  logic [n-1:0] data,
  output logic [n-1:0] a11,
  output logic [n-1:0] a12,
  output logic [n-1:0] a21,
  output logic [n-1:0] a22,
  output logic [n-1:0] b1,
  output logic [n-1:0] b2
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a11 <= '0;
      a12 <= '0;
      a21 <= '0;
      a22 <= '0;
      b1  <= '0;
      b2  <= '0;
    end else if (we) begin
      case (addr)
        A11:     a11 <= data;
        A12:     a12 <= data;
        A21:     a21 <= data;
        A22:     a22 <= data;
        B1:      b1  <= data;
        B2:      b2  <= data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/affine_seq.sv
// Multi-cycle 2-D affine transform sequencer driving one shared ALU:
//   x' = a11*x + a12*y + b1,  y' = a21*x + a22*y + b2
// One ALU operation per cycle; every ALU result is registered.
//   clk, reset          : clock, asynchronous active-high reset
//   cfg_we/addr/data    : coefficient write, honoured only in IDLE
//   cfg_ready           : high in IDLE
//   in_valid/in_ready   : input point handshake, x_in/y_in
//   out_valid/out_ready : result handshake, x_out/y_out
//   alu_a/alu_b/alu_func: operands and function code to the external ALU
//   alu_result          : combinational ALU result
//   busy                : high in every state except IDLE
//   dbg_state           : current sequencer state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready/cfg_ready/out_valid are pure decodes of state, so no
// input reaches them combinationally; out_valid stays high and x_out/y_out
// stay stable until the edge where out_ready is seen.
module affine_seq
  import affine_seq_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_we,
  input  logic [2:0]   cfg_addr,
  input  logic [n-1:0] cfg_data,
  output logic         cfg_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] x_in,
  input  logic [n-1:0] y_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] x_out,
  output logic [n-1:0] y_out,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [1:0]   alu_func,
  input  logic [n-1:0] alu_result,
  output logic         busy,
  output state_t       dbg_state
);

  state_t       state, state_n;
  logic [n-1:0] x_lat, y_lat, acc, tmp;
  logic [n-1:0] a11, a12, a21, a22, b1, b2;
  logic         coef_we;

  // Writes outside IDLE are dropped. A write in the same IDLE cycle as a
  // point accept lands before M11 reads the register file, so that point
  // already sees the new value.
  assign coef_we = cfg_we && (state == ST_IDLE);

  affine_seq_coef_rf #(.n(n)) u_coef_rf (
    .clk   (clk),
    .reset (reset),
    .we    (coef_we),
    .addr  (cfg_addr),
    .data  (cfg_data),
    .a11   (a11),
    .a12   (a12),
    .a21   (a21),
    .a22   (a22),
    .b1    (b1),
    .b2    (b2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      x_lat <= '0;
      y_lat <= '0;
      acc   <= '0;
      tmp   <= '0;
      x_out <= '0;
      y_out <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_lat <= x_in;
            y_lat <= y_in;
          end
        end
        // acc restarts at M21, so the y chain reuses it after B1.
        ST_M11, ST_S1, ST_M21, ST_S2: acc <= alu_result;
        ST_M12, ST_M22:               tmp <= alu_result;
        ST_B1:                        x_out <= alu_result;
        ST_B2:                        y_out <= alu_result;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    alu_func  = RA;
    alu_a     = '0;
    alu_b     = '0;
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready  = 1'b1;
        cfg_ready = 1'b1;
        if (in_valid) state_n = ST_M11;
      end
      ST_M11: begin
        alu_func = RMUL; alu_a = a11; alu_b = x_lat; state_n = ST_M12;
      end
      ST_M12: begin
        alu_func = RMUL; alu_a = a12; alu_b = y_lat; state_n = ST_S1;
      end
      ST_S1: begin
        alu_func = RADD; alu_a = acc; alu_b = tmp;   state_n = ST_B1;
      end
      ST_B1: begin
        alu_func = RADD; alu_a = acc; alu_b = b1;    state_n = ST_M21;
      end
      ST_M21: begin
        alu_func = RMUL; alu_a = a21; alu_b = x_lat; state_n = ST_M22;
      end
      ST_M22: begin
        alu_func = RMUL; alu_a = a22; alu_b = y_lat; state_n = ST_S2;
      end
      ST_S2: begin
        alu_func = RADD; alu_a = acc; alu_b = tmp;   state_n = ST_B2;
      end
      ST_B2: begin
        alu_func = RADD; alu_a = acc; alu_b = b2;    state_n = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: doc/affine_seq.md
Name: affine_seq

Overview:
Multi-cycle sequencer that computes a 2-D affine transform using one shared picoMIPS ALU instance:
- x' = a11*x + a12*y + b1
- y' = a21*x + a22*y + b2

It holds six Q1.7 coefficients in a small config register file. It drives the ALU operand and function inputs one operation per cycle and registers each ALU result. It sits between the point-input/point-output interfaces and the ALU, in place of a general instruction decoder.

Parameters:
- n, 8, data width of coordinates, coefficients and ALU operands.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  3  coefficient select: 0=a11, 1=a12, 2=a21, 3=a22, 4=b1, 5=b2; 6 and 7 unused.
- cfg_data  in  n  coefficient value, signed Q1.7 (b1/b2 are plain signed integers).
- cfg_ready  out  1  high when a config write will be accepted (state IDLE).
- in_valid  in  1  point offered.
- in_ready  out  1  point can be accepted.
- x_in, y_in  in  n  signed input point.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- x_out, y_out  out  n  signed transformed point.
- alu_a, alu_b  out  n  signed ALU operands.
- alu_func  out  2  ALU function code.
- alu_result  in  n  signed combinational ALU result.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - All six coefficients, acc, tmp, x/y latches, x_out and y_out cleared to 0.
  - out_valid=0, busy=0.
- Reset mid-operation aborts the computation immediately. No partial result is ever presented.
- States, in order: IDLE, M11, M12, S1, B1, M21, M22, S2, B2, DONE. Each compute state lasts exactly 1 cycle.
- IDLE:
  - in_ready=1, cfg_ready=1.
  - alu_func=RA, alu_a=alu_b=0.
  - cfg_we=1 with cfg_addr 0..5 writes that coefficient at the clock edge. Addresses 6 and 7 are ignored.
  - in_valid=1 latches x_in and y_in and moves to M11.
  - If cfg_we and in_valid are both high in the same cycle, both take effect. The new coefficient is used by the point accepted in that cycle.
- Compute states (ALU result registered at the end of each cycle):
  - M11: a=a11, b=x, RMUL, acc<=result.
  - M12: a=a12, b=y, RMUL, tmp<=result.
  - S1: a=acc, b=tmp, RADD, acc<=result.
  - B1: a=acc, b=b1, RADD, x_out<=result.
  - M21, M22, S2, B2: same pattern with a21, a22 and b2; B2 writes y_out.
- Latency: the accept edge is k. State reaches DONE at edge k+8, and out_valid=1 from that cycle.
- DONE:
  - out_valid=1. x_out and y_out are held stable until out_ready=1.
  - Then go to IDLE; out_valid drops at the next edge.
  - in_ready=0 in DONE, so a new point never overlaps a pending result.
- Config writes while busy (not IDLE) are ignored. cfg_ready=0 there.
- Arithmetic is fully delegated to the ALU:
  - RMUL is the Q1.7 product, i.e. bits [14:7] of the 2n-bit product.
  - RADD wraps modulo 2^n with no saturation.
  - The sequencer never widens values.
- in_ready, cfg_ready, busy and the ALU drive signals are combinational decodes of state only, with no input-to-output paths. out_valid is decoded from state DONE.

Decomposition:
- Shared package: state enum type; coefficient address constants (A11..B2); ALU function codes RA/RB/RADD/RMUL, reusing the existing ALU code definitions rather than redefining values.
- Natural sub-module: affine_coef_rf (6×n register file with async-reset, write port and six parallel read outputs).
- The ALU stays outside this block. The top level wires alu_a, alu_b, alu_func and alu_result to the existing ALU instance.

Test Plan:
- Scaling: a11=64, a22=64, a12=a21=0, b1=5, b2=-3; point (40, -20). Expect (25, -13); out_valid exactly 8 cycles after the accept edge.
- Wrap: a11=a12=127, b1=0; point (127, 127). Expect x_out=-4 (126+126 wraps); the ALU operand/func sequence matches the state list cycle by cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Expect out_valid, x_out and y_out stable, in_ready=0; result consumed on the first out_ready=1 cycle.
- Config gating: write a11=32 while busy. Expect it ignored (next point still uses the old value). Write in IDLE together with in_valid; expect the new value applied to that point.
- Reset mid-run: assert reset during S1. Expect immediate IDLE, out_valid=0, coefficients 0; the next point (10, 10) yields (0, 0) with b=0.
- Back-to-back: offer in_valid continuously for 3 points. Expect one accept per 10-cycle round (IDLE→…→DONE→IDLE) and in-order results.
